// File: rtl/imem_loader.sv
// imem_loader: assembles big-endian words from a byte stream and writes them to instruction sram at consecutive addresses.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] word_count,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        sram_cs,
  output logic        sram_we,
  output logic        sram_oe,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_din,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic        cpu_hold,
  output logic [15:0] words_written
);
  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_count, r_wcnt;
  logic [31:0] r_addr, r_din;
  logic [1:0]  r_bcnt;
  logic        r_err;
  logic        w_arm, w_accept, w_last, w_over, w_zero;
  assign w_arm    = start & ((r_state == IDLE) | (r_state == DONE));
  assign w_accept = byte_valid & byte_ready;
  assign w_last   = (r_wcnt + 16'd1) == r_count;
  assign w_over   = 32'(word_count) > MAX_WORDS;
  assign w_zero   = word_count == 16'd0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE: w_next = w_arm ? ((w_zero | w_over) ? DONE : COLLECT) : r_state;
      COLLECT:    w_next = (w_accept && r_bcnt == 2'd3) ? WRITE : COLLECT;
      WRITE:      w_next = w_last ? DONE : COLLECT;
      default:    w_next = IDLE;
    endcase
  end
  // A new arm restarts from a clean word: byte counter and address rewind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wcnt  <= '0;
      r_addr  <= BASE_ADDR;
      r_din   <= '0;
      r_bcnt  <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_arm) begin
        r_count <= word_count;
        r_wcnt  <= '0;
        r_addr  <= BASE_ADDR;
        r_bcnt  <= '0;
        r_err   <= w_over;
      end
      if (w_accept) begin
        r_din  <= {r_din[23:0], byte_data};
        r_bcnt <= r_bcnt + 2'd1;
      end
      if (r_state == WRITE) begin
        r_wcnt <= r_wcnt + 16'd1;
        if (!w_last) r_addr <= r_addr + 32'd4;
      end
    end
  end
  assign byte_ready    = r_state == COLLECT;
  assign sram_cs       = r_state == WRITE;
  assign sram_we       = r_state == WRITE;
  assign sram_oe       = 1'b0;
  assign sram_addr     = r_addr;
  assign sram_din      = r_din;
  assign busy          = (r_state == COLLECT) | (r_state == WRITE);
  assign cpu_hold      = busy;
  assign done          = r_state == DONE;
  assign error         = r_err;
  assign words_written = r_wcnt;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized byte-stream loads checked every cycle against a transaction-level loader model.
module tb_imem_loader;
  localparam int MAXW = 1024;
  logic        clk = 1'b0;
  logic        rst_n, start, byte_valid;
  logic [15:0] word_count;
  logic [7:0]  byte_data;
  logic        byte_ready, sram_cs, sram_we, sram_oe, busy, done, error, cpu_hold;
  logic [31:0] sram_addr, sram_din;
  logic [15:0] words_written;
  imem_loader #(.BASE_ADDR(32'h0), .MAX_WORDS(MAXW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .sram_cs(sram_cs), .sram_we(sram_we), .sram_oe(sram_oe), .sram_addr(sram_addr),
    .sram_din(sram_din), .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold),
    .words_written(words_written)
  );
  always #5 clk = ~clk;
  int          asserts = 0, fails = 0, n_strobes = 0, gap_pct = 0;
  logic [31:0] img [64];
  logic [31:0] mem [1024];
  logic [7:0]  src_q [$];
  bit          acc = 1'b0;
  int          m_busy = 0, m_wr = 0, m_done = 0, m_err = 0, m_ww = 0, m_bytes = 0, m_n = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: bytes accepted while loading; a write follows every 4th byte; done after N writes.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      m_busy = 0; m_wr = 0; m_done = 0; m_err = 0; m_ww = 0; m_bytes = 0;
      acc = 1'b0;
    end else begin
      int arm;
      chk("byte_ready", 32'(byte_ready), (m_busy != 0 && m_wr == 0) ? 1 : 0);
      chk("sram_we", 32'(sram_we), m_wr);
      chk("sram_cs", 32'(sram_cs), m_wr);
      chk("sram_oe", 32'(sram_oe), 0);
      chk("busy", 32'(busy), m_busy);
      chk("cpu_hold", 32'(cpu_hold), m_busy);
      chk("done", 32'(done), m_done);
      chk("error", 32'(error), m_err);
      chk("words_written", 32'(words_written), m_ww);
      if (m_wr != 0) begin
        chk("sram_addr", sram_addr, 32'(m_ww * 4));
        chk("sram_din", sram_din, (m_ww < 64) ? img[m_ww] : 32'h0);
      end
      if (sram_cs && sram_we) begin
        mem[sram_addr[11:2]] = sram_din;
        n_strobes++;
      end
      acc = byte_valid && byte_ready;
      arm = (m_busy == 0 && start) ? 1 : 0;
      if (m_wr != 0) begin
        m_wr = 0;
        m_ww++;
        if (m_ww == m_n) begin m_busy = 0; m_done = 1; end
      end else if (m_busy != 0 && byte_valid) begin
        m_bytes++;
        if (m_bytes % 4 == 0) m_wr = 1;
      end
      if (arm != 0) begin
        m_n = int'(word_count); m_ww = 0; m_bytes = 0;
        m_err = (int'(word_count) > MAXW) ? 1 : 0;
        m_done = (m_n == 0 || m_err != 0) ? 1 : 0;
        m_busy = 1 - m_done;
      end
    end
  end
  initial begin
    byte_valid = 1'b0;
    byte_data = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) src_q.delete();
      else if (acc && src_q.size() > 0) void'(src_q.pop_front());
      byte_valid = rst_n && src_q.size() > 0 && ($urandom_range(99) >= gap_pct);
      byte_data = (src_q.size() > 0) ? src_q[0] : 8'h00;
    end
  end
  task automatic rand_img(input int n);
    for (int i = 0; i < n; i++) img[i] = $urandom;
  endtask
  task automatic push_img(input int n);
    for (int i = 0; i < n; i++)
      for (int b = 3; b >= 0; b--) src_q.push_back(img[i][8*b +: 8]);
  endtask
  task automatic arm_load(input int wc);
    @(posedge clk); #1;
    start = 1'b1;
    word_count = 16'(wc);
    @(posedge clk); #1;
    start = 1'b0;
  endtask
  task automatic wait_done(output int c);
    c = 0;
    while (!done && c < 20000) begin @(posedge clk); #1; c++; end
    chk("done_timeout", 32'(done), 1);
  endtask
  task automatic readback(input string name, input int n);
    for (int pc = 0; pc < 4 * n; pc += 4) chk(name, mem[pc >> 2], img[pc >> 2]);
  endtask
  initial begin
    int c, s0;
    rst_n = 1'b0; start = 1'b0; word_count = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    img[0] = 32'h8C22_0004;
    push_img(1);
    s0 = n_strobes;
    arm_load(1); wait_done(c);
    chk("single_cycles", c, 5);
    chk("single_ww", 32'(words_written), 1);
    chk("single_mem", mem[0], 32'h8C22_0004);
    chk("single_strobes", n_strobes - s0, 1);
    s0 = n_strobes;
    arm_load(0); wait_done(c);
    chk("zero_cycles", c, 0);
    chk("zero_error", 32'(error), 0);
    chk("zero_strobes", n_strobes - s0, 0);
    arm_load(MAXW + 1); wait_done(c);
    chk("over_cycles", c, 0);
    chk("over_error", 32'(error), 1);
    chk("over_strobes", n_strobes - s0, 0);
    rand_img(55); push_img(55);
    s0 = n_strobes;
    arm_load(55); wait_done(c);
    chk("full_cycles", c, 275);
    chk("full_strobes", n_strobes - s0, 55);
    chk("full_error_cleared", 32'(error), 0);
    readback("full_readback", 55);
    gap_pct = 40;
    rand_img(55); push_img(55);
    s0 = n_strobes;
    arm_load(55); wait_done(c);
    chk("throttle_strobes", n_strobes - s0, 55);
    chk("throttle_ww", 32'(words_written), 55);
    readback("throttle_readback", 55);
    gap_pct = 0;
    rand_img(3); push_img(3);
    s0 = n_strobes;
    arm_load(3);
    repeat (6) @(posedge clk);
    arm_load(9);
    wait_done(c);
    chk("busy_start_ww", 32'(words_written), 3);
    chk("busy_start_strobes", n_strobes - s0, 3);
    rand_img(2); push_img(2);
    arm_load(2); wait_done(c);
    chk("restart_cycles", c, 10);
    chk("restart_mem0", mem[0], img[0]);
    chk("restart_mem1", mem[1], img[1]);
    rand_img(4); push_img(4);
    arm_load(4);
    repeat (7) @(posedge clk);
    #3 rst_n = 1'b0;
    src_q.delete();
    #1;
    chk("rst_byte_ready", 32'(byte_ready), 0);
    chk("rst_sram_cs", 32'(sram_cs), 0);
    chk("rst_sram_we", 32'(sram_we), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cpu_hold", 32'(cpu_hold), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_addr", sram_addr, 32'h0);
    chk("rst_din", sram_din, 32'h0);
    chk("rst_ww", 32'(words_written), 0);
    s0 = n_strobes;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_strobes", n_strobes - s0, 0);
    chk("post_rst_busy", 32'(busy), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
